// File: rtl/huffman_block_sequencer_if.sv
// Handshake and data bundle between the Huffman block sequencer, the
// stream unpacker, the Huffman decoder lookup and the dequantiser.
interface huffman_block_sequencer_if;
    logic        start;
    logic [15:0] bits_in;
    logic        bits_valid;
    logic        bits_ready;
    logic        tbl_sel;
    logic [15:0] dec_code;
    logic        dec_valid;
    logic [3:0]  dec_run;
    logic [3:0]  dec_vli_size;
    logic [3:0]  dec_code_size;
    logic        dec_hit;
    logic        coef_valid;
    logic        coef_ready;
    logic [5:0]  coef_index;
    logic [11:0] coef_value;
    logic        block_done;
    logic        error;

    // Environment side: stream source, decoder and coefficient sink.
    modport master (
        output start, bits_in, bits_valid, dec_run, dec_vli_size, dec_code_size,
               dec_hit, coef_ready,
        input  bits_ready, tbl_sel, dec_code, dec_valid, coef_valid, coef_index,
               coef_value, block_done, error
    );

    // Sequencer side.
    modport slave (
        input  start, bits_in, bits_valid, dec_run, dec_vli_size, dec_code_size,
               dec_hit, coef_ready,
        output bits_ready, tbl_sel, dec_code, dec_valid, coef_valid, coef_index,
               coef_value, block_done, error
    );
endinterface

// File: rtl/huffman_block_sequencer.sv
// Huffman block sequencer: keeps an LSB-first bit buffer topped up from the
// entropy stream, drives one decoder lookup per symbol (DC table for index 0,
// AC table afterwards), consumes code and VLI bits and emits signed
// coefficients tagged with their zig-zag index.
module huffman_block_sequencer #(
    parameter int BUF_W = 32,
    parameter int NCOEF = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    huffman_block_sequencer_if.slave    bus
);
    localparam int                OCC_W      = $clog2(BUF_W + 1);
    localparam logic [OCC_W-1:0]  LOAD_LIMIT = OCC_W'(BUF_W - 16);
    localparam logic [OCC_W-1:0]  WORD_BITS  = OCC_W'(16);
    localparam logic [6:0]        LAST_IDX   = 7'(NCOEF - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_VLI    = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [5:0]         index_q, index_d;
    logic               tbl_sel_q, tbl_sel_d;
    logic [3:0]         s_q, s_d;
    logic [11:0]        coef_value_q, coef_value_d;

    logic [4:0]         consume_s;
    logic [6:0]         next_index_s;
    logic               bits_ready_s;
    logic               load_s;
    logic               dec_valid_s;
    logic               zrl_s;
    logic [OCC_W-1:0]   occ_after_s;
    logic [BUF_W-1:0]   shifted_s;

    // Extract an s-bit VLI (first stream bit = MSB) and map it to its signed value.
    function automatic logic [11:0] vli_decode(input logic [BUF_W-1:0] bits,
                                               input logic [3:0] size);
        logic [10:0] raw;
        logic [11:0] offset;
        logic [11:0] result;
        raw = 11'd0;
        for (int i = 0; i < 11; i++) begin
            if (i < int'(size)) begin
                raw = {raw[9:0], bits[i]};
            end else begin
                raw = raw;
            end
        end
        offset = (12'd1 << size) - 12'd1;
        if (size == 4'd0) begin
            result = 12'd0;
        end else if (raw[size - 4'd1]) begin
            result = {1'b0, raw};
        end else begin
            result = {1'b0, raw} - offset;
        end
        return result;
    endfunction

    assign bits_ready_s = (state_q != S_ERR) && (occ_q <= LOAD_LIMIT);
    assign load_s       = bus.bits_valid && bits_ready_s;
    assign dec_valid_s  = (state_q == S_DECODE) && (occ_q >= WORD_BITS);
    assign zrl_s        = (bus.dec_run == 4'd15) && (bus.dec_vli_size == 4'd0);

    assign bus.bits_ready = bits_ready_s;
    assign bus.dec_valid  = dec_valid_s;
    assign bus.dec_code   = buf_q[15:0];
    assign bus.tbl_sel    = tbl_sel_q;
    assign bus.coef_valid = (state_q == S_EMIT);
    assign bus.coef_index = index_q;
    assign bus.coef_value = coef_value_q;
    assign bus.block_done = (state_q == S_DONE);
    assign bus.error      = (state_q == S_ERR);

    // Block sequencing: next state, index/table tracking and bits consumed this cycle.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        tbl_sel_d    = tbl_sel_q;
        s_d          = s_q;
        coef_value_d = coef_value_q;
        consume_s    = 5'd0;
        next_index_s = 7'd0;
        if (bus.start) begin
            // A start always restarts the block; the buffer contents are kept.
            state_d   = S_DECODE;
            index_d   = 6'd0;
            tbl_sel_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DECODE: begin
                    if (!dec_valid_s) begin
                        state_d = S_DECODE;
                    end else if (!bus.dec_hit) begin
                        state_d = S_ERR;
                    end else begin
                        consume_s = {1'b0, bus.dec_code_size};
                        s_d       = bus.dec_vli_size;
                        if (bus.dec_vli_size > 4'd11) begin
                            state_d = S_ERR;
                        end else if (!tbl_sel_q) begin
                            // DC symbol: a zero-size difference is emitted directly as 0.
                            if (bus.dec_vli_size == 4'd0) begin
                                coef_value_d = 12'd0;
                                state_d      = S_EMIT;
                            end else begin
                                state_d = S_VLI;
                            end
                        end else if ((bus.dec_run == 4'd0) && (bus.dec_vli_size == 4'd0)) begin
                            state_d = S_DONE;
                        end else begin
                            if (zrl_s) begin
                                next_index_s = {1'b0, index_q} + 7'd16;
                            end else begin
                                next_index_s = {1'b0, index_q} + {3'd0, bus.dec_run};
                            end
                            if (next_index_s > LAST_IDX) begin
                                state_d = S_ERR;
                            end else begin
                                index_d = next_index_s[5:0];
                                state_d = zrl_s ? S_DECODE : S_VLI;
                            end
                        end
                    end
                end
                S_VLI: begin
                    if (occ_q >= OCC_W'(s_q)) begin
                        consume_s    = {1'b0, s_q};
                        coef_value_d = vli_decode(buf_q, s_q);
                        state_d      = S_EMIT;
                    end else begin
                        state_d = S_VLI;
                    end
                end
                S_EMIT: begin
                    if (!bus.coef_ready) begin
                        state_d = S_EMIT;
                    end else if ({1'b0, index_q} == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d   = index_q + 6'd1;
                        tbl_sel_d = 1'b1;
                        state_d   = S_DECODE;
                    end
                end
                S_DONE: begin
                    tbl_sel_d = 1'b0;
                    state_d   = S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Bit buffer: drop consumed bits from the bottom, append a loaded word above the survivors.
    always_comb begin
        occ_after_s = occ_q - OCC_W'(consume_s);
        shifted_s   = buf_q >> consume_s;
        if (load_s) begin
            buf_d = shifted_s | (BUF_W'(bus.bits_in) << occ_after_s);
            occ_d = occ_after_s + WORD_BITS;
        end else begin
            buf_d = shifted_s;
            occ_d = occ_after_s;
        end
    end

    // State and datapath registers; reset discards the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            occ_q        <= '0;
            index_q      <= 6'd0;
            tbl_sel_q    <= 1'b0;
            s_q          <= 4'd0;
            coef_value_q <= 12'd0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            occ_q        <= occ_d;
            index_q      <= index_d;
            tbl_sel_q    <= tbl_sel_d;
            s_q          <= s_d;
            coef_value_q <= coef_value_d;
        end
    end
endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Self-checking bench for huffman_block_sequencer: a small code table acts as
// the Huffman decoder, directed symbol lists are encoded into the bit stream,
// and a symbol-level model predicts the coefficient sequence of each block.
module tb_huffman_block_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    huffman_block_sequencer_if bus ();

    huffman_block_sequencer #(.BUF_W(32), .NCOEF(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct { int idx; int val; } coef_t;

    int    checks = 0;
    int    passes = 0;
    bit    feed_q[$];
    coef_t exp_q[$];
    int    log_idx[$];
    int    log_val[$];
    int    done_cnt = 0;
    int    done_base = 0;
    int    m_idx = 0;
    int    m_done = 0;
    bit    m_err = 1'b0;
    logic  hs_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Decoder code table (stream order, first bit = dec_code[0]).
    // DC: 00 s0 | 01 s1 | 10 s3 | 110 s2 | 111 s12
    // AC: 00 EOB | 01 run2/s1 | 10 ZRL | 110 run15/s1 | 1110 run0/s2 | 1111 miss
    always_comb begin
        bus.dec_hit       = 1'b0;
        bus.dec_run       = 4'd0;
        bus.dec_vli_size  = 4'd0;
        bus.dec_code_size = 4'd0;
        if (bus.dec_valid) begin
            if (!bus.tbl_sel) begin
                bus.dec_hit = 1'b1;
                case ({bus.dec_code[0], bus.dec_code[1]})
                    2'b00:   begin bus.dec_code_size = 4'd2; bus.dec_vli_size = 4'd0; end
                    2'b01:   begin bus.dec_code_size = 4'd2; bus.dec_vli_size = 4'd1; end
                    2'b10:   begin bus.dec_code_size = 4'd2; bus.dec_vli_size = 4'd3; end
                    default: begin
                        bus.dec_code_size = 4'd3;
                        bus.dec_vli_size  = bus.dec_code[2] ? 4'd12 : 4'd2;
                    end
                endcase
            end else begin
                case ({bus.dec_code[0], bus.dec_code[1]})
                    2'b00: begin bus.dec_hit = 1'b1; bus.dec_code_size = 4'd2; end
                    2'b01: begin
                        bus.dec_hit = 1'b1; bus.dec_code_size = 4'd2;
                        bus.dec_run = 4'd2; bus.dec_vli_size = 4'd1;
                    end
                    2'b10: begin bus.dec_hit = 1'b1; bus.dec_code_size = 4'd2; bus.dec_run = 4'd15; end
                    default: begin
                        if (!bus.dec_code[2]) begin
                            bus.dec_hit = 1'b1; bus.dec_code_size = 4'd3;
                            bus.dec_run = 4'd15; bus.dec_vli_size = 4'd1;
                        end else if (!bus.dec_code[3]) begin
                            bus.dec_hit = 1'b1; bus.dec_code_size = 4'd4;
                            bus.dec_vli_size = 4'd2;
                        end
                    end
                endcase
            end
        end
    end

    // Stream source: offers 16-bit words from feed_q, removes them on handshake.
    initial begin
        bus.bits_valid = 1'b0;
        bus.bits_in    = 16'd0;
        forever begin
            @(negedge clock);
            hs_in = bus.bits_valid && bus.bits_ready;
            @(posedge clock);
            #2;
            if (reset) feed_q.delete();
            else if (hs_in) feed_q = feed_q[16:$];
            if (!reset && feed_q.size() >= 16) begin
                for (int i = 0; i < 16; i++) bus.bits_in[i] = feed_q[i];
                bus.bits_valid = 1'b1;
            end else begin
                bus.bits_valid = 1'b0;
                bus.bits_in    = 16'd0;
            end
        end
    end

    // Compare process: every presented coefficient must match the model's next one.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.block_done) done_cnt++;
            if (bus.coef_valid) begin
                if (exp_q.size() == 0) begin
                    chk("coef_unexpected", 1, 0);
                end else begin
                    chk("coef_index", int'(bus.coef_index), exp_q[0].idx);
                    chk("coef_value", int'($signed(bus.coef_value)), exp_q[0].val);
                    if (bus.coef_ready) begin
                        log_idx.push_back(int'(bus.coef_index));
                        log_val.push_back(int'($signed(bus.coef_value)));
                        exp_q.delete(0);
                    end
                end
            end
        end
    end

    function automatic int vli_val(input int s, input int raw);
        if (s == 0) return 0;
        if (((raw >> (s - 1)) & 1) == 1) return raw;
        return raw - ((1 << s) - 1);
    endfunction

    function automatic int log_at(input bit want_idx, input int k);
        if (k >= log_val.size()) return 9999;
        return want_idx ? log_idx[k] : log_val[k];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_bits(input int n, input int v);
        for (int i = n - 1; i >= 0; i--) feed_q.push_back(bit'((v >> i) & 1));
    endtask

    task automatic pad();
        repeat (3) push_bits(16, 0);
    endtask

    task automatic sym_dc(input int s, input int raw);
        coef_t c;
        case (s)
            0:  push_bits(2, 0);
            1:  push_bits(2, 1);
            3:  push_bits(2, 2);
            2:  push_bits(3, 6);
            12: push_bits(3, 7);
            default: chk("dc_table", s, -1);
        endcase
        push_bits(s, raw);
        if (!m_err) begin
            if (s > 11) m_err = 1'b1;
            else begin
                c.idx = 0; c.val = vli_val(s, raw);
                exp_q.push_back(c);
                m_idx = 1;
            end
        end
    endtask

    task automatic sym_ac(input int run, input int s, input int raw);
        coef_t c;
        if (run == 0 && s == 0)       push_bits(2, 0);
        else if (run == 2 && s == 1)  push_bits(2, 1);
        else if (run == 15 && s == 0) push_bits(2, 2);
        else if (run == 15 && s == 1) push_bits(3, 6);
        else if (run == 0 && s == 2)  push_bits(4, 14);
        else chk("ac_table", run, -1);
        push_bits(s, raw);
        if (!m_err) begin
            if (run == 0 && s == 0) m_done++;
            else if (run == 15 && s == 0) begin
                m_idx += 16;
                if (m_idx > 63) m_err = 1'b1;
            end else begin
                m_idx += run;
                if (m_idx > 63) m_err = 1'b1;
                else begin
                    c.idx = m_idx; c.val = vli_val(s, raw);
                    exp_q.push_back(c);
                    if (m_idx == 63) m_done++;
                    else m_idx++;
                end
            end
        end
    endtask

    task automatic miss();
        push_bits(4, 15);
        m_err = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.coef_ready = 1'b1;
        exp_q.delete();
        m_idx = 0; m_done = 0; m_err = 1'b0;
        step();
        step();
        reset = 1'b0;
        done_base = done_cnt;
    endtask

    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while ((done_cnt - done_base) < target && n < 400) begin step(); n++; end
        chk("done_count", done_cnt - done_base, target);
    endtask

    task automatic wait_err();
        int n = 0;
        while (!bus.error && n < 400) begin step(); n++; end
        chk("error_set", int'(bus.error), 1);
    endtask

    task automatic end_block();
        step();
        chk("exp_drained", exp_q.size(), 0);
        chk("done_total", done_cnt - done_base, m_done);
        chk("error_model", int'(bus.error), int'(m_err));
    endtask

    initial begin
        int lb;
        int n;
        bus.start = 1'b0;
        bus.coef_ready = 1'b1;

        // 1: reset state
        do_reset();
        step();
        chk("rst_bits_ready", int'(bus.bits_ready), 1);
        chk("rst_coef_valid", int'(bus.coef_valid), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_tbl_sel", int'(bus.tbl_sel), 0);
        chk("rst_block_done", int'(bus.block_done), 0);
        chk("rst_dec_valid", int'(bus.dec_valid), 0);

        // 2a: DC s=3 bits 101 -> +5
        do_reset();
        sym_dc(3, 5); sym_ac(0, 0, 0); pad();
        lb = log_val.size();
        kick();
        wait_done(1);
        chk("dc_pos_idx", log_at(1'b1, lb), 0);
        chk("dc_pos_val", log_at(1'b0, lb), 5);
        end_block();

        // 2b: DC s=3 bits 010 -> -5
        do_reset();
        sym_dc(3, 2); sym_ac(0, 0, 0); pad();
        lb = log_val.size();
        kick();
        wait_done(1);
        chk("dc_neg_val", log_at(1'b0, lb), -5);
        end_block();

        // 3: AC run 2 s 1 bit 0 -> index 3, -1; EOB; second block from the kept buffer
        do_reset();
        sym_dc(3, 5); sym_ac(2, 1, 0); sym_ac(0, 0, 0);
        sym_dc(0, 0); sym_ac(0, 0, 0); pad();
        lb = log_val.size();
        kick();
        wait_done(1);
        step();
        chk("idle_tbl_sel", int'(bus.tbl_sel), 0);
        chk("ac_idx", log_at(1'b1, lb + 1), 3);
        chk("ac_val", log_at(1'b0, lb + 1), -1);
        kick();
        chk("restart_tbl_sel", int'(bus.tbl_sel), 0);
        wait_done(2);
        chk("blk2_dc_idx", log_at(1'b1, lb + 2), 0);
        chk("blk2_dc_val", log_at(1'b0, lb + 2), 0);
        end_block();

        // 4: three ZRLs then run 15 from index 49 overflows to 64
        do_reset();
        sym_dc(1, 1);
        repeat (3) sym_ac(15, 0, 0);
        sym_ac(15, 1, 1); pad();
        lb = log_val.size();
        kick();
        wait_err();
        chk("zrl_bits_ready", int'(bus.bits_ready), 0);
        chk("zrl_coef_valid", int'(bus.coef_valid), 0);
        chk("zrl_dec_valid", int'(bus.dec_valid), 0);
        chk("zrl_dc_val", log_at(1'b0, lb), 1);
        end_block();

        // 5: decoder miss, then start clears error; buffered 111 gives DC s=12 -> error again
        do_reset();
        sym_dc(0, 0); miss(); pad();
        kick();
        wait_err();
        chk("miss_bits_ready", int'(bus.bits_ready), 0);
        end_block();
        kick();
        chk("restart_error", int'(bus.error), 0);
        chk("restart_dec_valid", int'(bus.dec_valid), 1);
        chk("restart_dc_tbl", int'(bus.tbl_sel), 0);
        step();
        chk("dc_size12_error", int'(bus.error), 1);

        // 6: backpressure holds coefficient stable
        do_reset();
        sym_dc(3, 5); sym_ac(0, 2, 2); sym_ac(0, 0, 0); pad();
        lb = log_val.size();
        bus.coef_ready = 1'b0;
        kick();
        n = 0;
        while (!bus.coef_valid && n < 200) begin step(); n++; end
        chk("emit_seen", int'(bus.coef_valid), 1);
        repeat (5) begin
            step();
            chk("hold_valid", int'(bus.coef_valid), 1);
            chk("hold_index", int'(bus.coef_index), 0);
            chk("hold_value", int'($signed(bus.coef_value)), 5);
        end
        bus.coef_ready = 1'b1;
        wait_done(1);
        chk("bp_ac_idx", log_at(1'b1, lb + 1), 1);
        chk("bp_ac_val", log_at(1'b0, lb + 1), 2);
        end_block();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
